// File: rtl/i2c_ctrl.sv
// i2c_ctrl: single-master I2C controller performing one random-address byte
// write or one random-address byte read on an EEPROM-style slave per request.
//
// Ports:
//   sys_clk    in   system clock (only clock)
//   sys_rst    in   asynchronous active-high reset
//   wr_en      in   request a write (wins over rd_en)
//   rd_en      in   request a read
//   i2c_start  in   one-cycle request pulse, accepted only while idle
//   addr_num   in   0 = one address byte, 1 = two address bytes (high first)
//   byte_addr  in   16-bit memory address inside the slave
//   wr_data    in   byte to write
//   i2c_clk    out  quarter-bit clock (4 x SCL_FREQ)
//   i2c_end    out  one-cycle pulse at end of transaction
//   rd_data    out  last byte read
//   i2c_scl    out  SCL, push-pull
//   i2c_sda    inout SDA, open-drain (drives 0 or releases)
module i2c_ctrl #(
  parameter logic [6:0] DEVICE_ADDR  = 7'h50,
  parameter int         SYS_CLK_FREQ = 100_000_000,
  parameter int         SCL_FREQ     = 250_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        i2c_start,
  input  logic        addr_num,
  input  logic [15:0] byte_addr,
  input  logic [7:0]  wr_data,
  output logic        i2c_clk,
  output logic        i2c_end,
  output logic [7:0]  rd_data,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  localparam int CNT_MAX = SYS_CLK_FREQ / (SCL_FREQ * 8);
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, START_1, SEND_D_ADDR, ACK_1, SEND_B_ADDR_H, ACK_2, SEND_B_ADDR_L,
    ACK_3, WR_DATA, ACK_4, START_2, SEND_RD_ADDR, ACK_5, RD_DATA, N_ACK, STOP
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic        tick;
  logic [1:0]  q;
  logic [2:0]  bcnt;
  logic        bit_end;
  logic        pending, op_wr;
  logic        accept;
  logic        a2_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [7:0]  shift;
  logic [7:0]  tx_byte;
  logic        scl, sda_low;
  logic        sda_in;

  // Tick is the cycle in which i2c_clk is about to rise.
  assign tick    = !i2c_clk && (cnt == CW'(CNT_MAX - 1));
  assign bit_end = tick && (q == 2'd3);
  assign sda_in  = i2c_sda;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      i2c_clk <= 1'b0;
    end else if (cnt == CW'(CNT_MAX - 1)) begin
      cnt     <= '0;
      i2c_clk <= ~i2c_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A request arriving on the same cycle the pending one is consumed would
  // land after the FSM has left IDLE, so it is refused.
  assign accept = (state == IDLE) && !(tick && pending) && i2c_start && (wr_en || rd_en);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pending <= 1'b0;
      op_wr   <= 1'b0;
    end else if (accept) begin
      pending <= 1'b1;
      op_wr   <= wr_en;
    end else if (tick) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      a2_q   <= addr_num;
      addr_q <= byte_addr;
      data_q <= wr_data;
    end
  end

  // State register with quarter and bit counters
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      q     <= 2'd0;
      bcnt  <= 3'd0;
    end else if (tick) begin
      state <= state_nxt;
      if (state == IDLE) begin
        q    <= 2'd0;
        bcnt <= 3'd0;
      end else begin
        q <= q + 2'd1;
        if (q == 2'd3) bcnt <= (state_nxt != state) ? 3'd0 : bcnt + 3'd1;
      end
    end
  end

  // Next-state logic; non-idle states only move at the end of a bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (tick && pending) state_nxt = START_1;
      START_1:       if (bit_end) state_nxt = SEND_D_ADDR;
      SEND_D_ADDR:   if (bit_end && bcnt == 3'd7) state_nxt = ACK_1;
      ACK_1:         if (bit_end) state_nxt = a2_q ? SEND_B_ADDR_H : SEND_B_ADDR_L;
      SEND_B_ADDR_H: if (bit_end && bcnt == 3'd7) state_nxt = ACK_2;
      ACK_2:         if (bit_end) state_nxt = SEND_B_ADDR_L;
      SEND_B_ADDR_L: if (bit_end && bcnt == 3'd7) state_nxt = ACK_3;
      ACK_3:         if (bit_end) state_nxt = op_wr ? WR_DATA : START_2;
      WR_DATA:       if (bit_end && bcnt == 3'd7) state_nxt = ACK_4;
      ACK_4:         if (bit_end) state_nxt = STOP;
      START_2:       if (bit_end) state_nxt = SEND_RD_ADDR;
      SEND_RD_ADDR:  if (bit_end && bcnt == 3'd7) state_nxt = ACK_5;
      ACK_5:         if (bit_end) state_nxt = RD_DATA;
      RD_DATA:       if (bit_end && bcnt == 3'd7) state_nxt = N_ACK;
      N_ACK:         if (bit_end) state_nxt = STOP;
      STOP:          if (bit_end) state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  // Read shifting samples SDA at the end of q2, while SCL is still high.
  always_ff @(posedge sys_clk) begin
    if (tick && state == RD_DATA && q == 2'd2) shift <= {shift[6:0], sda_in};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_data <= 8'h00;
      i2c_end <= 1'b0;
    end else begin
      i2c_end <= (state == STOP) && bit_end;
      if (state == RD_DATA && bit_end && bcnt == 3'd7) rd_data <= shift;
    end
  end

  // Output logic
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      SEND_D_ADDR:   tx_byte = {DEVICE_ADDR, 1'b0};
      SEND_B_ADDR_H: tx_byte = addr_q[15:8];
      SEND_B_ADDR_L: tx_byte = addr_q[7:0];
      WR_DATA:       tx_byte = data_q;
      SEND_RD_ADDR:  tx_byte = {DEVICE_ADDR, 1'b1};
      default:       tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state)
      IDLE: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
      START_1, START_2: begin
        scl     = (q == 2'd1) || (q == 2'd2);
        sda_low = q[1];
      end
      STOP: begin
        scl     = (q != 2'd0);
        sda_low = !q[1];
      end
      SEND_D_ADDR, SEND_B_ADDR_H, SEND_B_ADDR_L, WR_DATA, SEND_RD_ADDR: begin
        scl     = (q == 2'd1) || (q == 2'd2);
        sda_low = !tx_byte[~bcnt];
      end
      default: begin
        scl     = (q == 2'd1) || (q == 2'd2);
        sda_low = 1'b0;
      end
    endcase
  end

  assign i2c_scl = scl;
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_ctrl.sv
// Directed testbench for i2c_ctrl: decodes the SCL/SDA bus, models a simple
// read slave and checks bus content, timing and status outputs.
module tb_i2c_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, i2c_start = 1'b0, addr_num = 1'b0;
  logic [15:0] byte_addr = 16'h0;
  logic [7:0]  wr_data = 8'h0;
  wire         i2c_clk, i2c_end, i2c_scl;
  wire  [7:0]  rd_data;
  wire         i2c_sda;

  int n_chk = 0;
  int n_err = 0;

  logic bits [0:63];
  int   nbits = 0, nstart = 0, nstop = 0;
  int   lat, len, nend;
  logic slv_en = 1'b0;
  logic slv_low = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  int   slv_first = 29;

  i2c_ctrl #(.DEVICE_ADDR(7'h50), .SYS_CLK_FREQ(100_000_000), .SCL_FREQ(250_000)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wr_en), .rd_en(rd_en),
    .i2c_start(i2c_start), .addr_num(addr_num), .byte_addr(byte_addr),
    .wr_data(wr_data), .i2c_clk(i2c_clk), .i2c_end(i2c_end), .rd_data(rd_data),
    .i2c_scl(i2c_scl), .i2c_sda(i2c_sda)
  );

  always #5 sys_clk = ~sys_clk;

  pullup (i2c_sda);
  assign i2c_sda = slv_low ? 1'b0 : 1'bz;

  // Bus decoder: one entry per SCL rising edge, plus START/STOP detection
  always @(posedge i2c_scl) begin
    if (nbits < 64) bits[nbits] = i2c_sda;
    nbits++;
  end
  always @(negedge i2c_sda) if (i2c_scl === 1'b1) nstart++;
  always @(posedge i2c_sda) if (i2c_scl === 1'b1) nstop++;

  // Read slave: presents slv_byte MSB first on bits slv_first..slv_first+7
  always @(negedge i2c_scl) begin
    if (slv_en && nbits >= slv_first && nbits <= slv_first + 7)
      slv_low = ~slv_byte[7 - (nbits - slv_first)];
    else
      slv_low = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int s);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits[s + i]};
    return b;
  endfunction

  task automatic run_txn(input logic w, input logic r, input logic an,
                         input logic [15:0] ba, input logic [7:0] wd, input logic poke);
    int c = 0;
    int t0 = -1;
    int after = 0;
    @(negedge sys_clk);
    nbits = 0; nstart = 0; nstop = 0; lat = -1; len = -1; nend = 0;
    wr_en = w; rd_en = r; addr_num = an; byte_addr = ba; wr_data = wd;
    i2c_start = 1'b1;
    while (c < 20000 && after < 500) begin
      @(negedge sys_clk);
      c++;
      if (c == 1) i2c_start = 1'b0;
      if (poke && c == 2000) begin
        i2c_start = 1'b1; wr_en = 1'b0; rd_en = 1'b1;
        byte_addr = 16'hFFFF; wr_data = 8'h00; addr_num = ~an;
      end
      if (poke && c == 2001) i2c_start = 1'b0;
      if (t0 < 0 && i2c_scl == 1'b0) begin
        t0  = c;
        lat = c;
      end
      if (i2c_end) begin
        nend++;
        if (len < 0) len = c - t0;
      end
      if (nend > 0) after++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int c;
    // Reset, then reassert mid-divider
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (37) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_scl", i2c_scl, 1'b1);
    check("rst_sda_released", i2c_sda, 1'b1);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_i2c_clk", i2c_clk, 1'b0);
    check("rst_i2c_end", i2c_end, 1'b0);
    sys_rst = 1'b0;
    c = 0;
    do begin @(negedge sys_clk); c++; end while (!i2c_clk && c < 1000);
    check("clk_first_rise", c, 50);
    c = 0;
    do begin @(negedge sys_clk); c++; end while (i2c_clk && c < 1000);
    do begin @(negedge sys_clk); c++; end while (!i2c_clk && c < 1000);
    check("clk_period", c, 100);

    // Write, one address byte
    run_txn(1'b1, 1'b0, 1'b0, 16'h0012, 8'hA5, 1'b0);
    check("w1_bits", nbits, 29);
    check("w1_start", nstart, 1);
    check("w1_stop", nstop, 1);
    check("w1_dev", get_byte(1), 8'hA0);
    check("w1_ack", bits[9], 1'b1);
    check("w1_addr", get_byte(10), 8'h12);
    check("w1_data", get_byte(19), 8'hA5);
    check("w1_end_cnt", nend, 1);
    check("w1_len", len, 29 * 400);
    check("w1_lat_ok", (lat >= 2 && lat <= 101), 1'b1);
    check("w1_idle_scl", i2c_scl, 1'b1);
    check("w1_idle_sda", i2c_sda, 1'b1);

    // Write, two address bytes
    run_txn(1'b1, 1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0);
    check("w2_bits", nbits, 38);
    check("w2_dev", get_byte(1), 8'hA0);
    check("w2_addr_h", get_byte(10), 8'h12);
    check("w2_addr_l", get_byte(19), 8'h34);
    check("w2_data", get_byte(28), 8'h5A);
    check("w2_end_cnt", nend, 1);
    check("w2_len", len, 38 * 400);

    // Read, one address byte, slave returns 3C
    slv_en = 1'b1; slv_byte = 8'h3C; slv_first = 29;
    run_txn(1'b0, 1'b1, 1'b0, 16'h0055, 8'h00, 1'b0);
    slv_en = 1'b0;
    check("r1_bits", nbits, 39);
    check("r1_start", nstart, 2);
    check("r1_stop", nstop, 1);
    check("r1_dev_w", get_byte(1), 8'hA0);
    check("r1_addr", get_byte(10), 8'h55);
    check("r1_dev_r", get_byte(20), 8'hA1);
    check("r1_bus_data", get_byte(29), 8'h3C);
    check("r1_nack", bits[37], 1'b1);
    check("r1_rd_data", rd_data, 8'h3C);
    check("r1_end_cnt", nend, 1);
    check("r1_len", len, 39 * 400);

    // Both enables high runs as a write; a mid-transaction request is ignored
    run_txn(1'b1, 1'b1, 1'b0, 16'h0077, 8'hC3, 1'b1);
    check("b_bits", nbits, 29);
    check("b_start", nstart, 1);
    check("b_dev", get_byte(1), 8'hA0);
    check("b_addr", get_byte(10), 8'h77);
    check("b_data", get_byte(19), 8'hC3);
    check("b_end_cnt", nend, 1);
    check("b_rd_hold", rd_data, 8'h3C);

    // Request with no enable is dropped
    @(negedge sys_clk);
    nbits = 0; nend = 0;
    addr_num = 1'b0;
    i2c_start = 1'b1;
    @(negedge sys_clk);
    i2c_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (i2c_end) nend++;
    end
    check("n_bits", nbits, 0);
    check("n_end", nend, 0);
    check("n_scl", i2c_scl, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
